// File: rtl/data_bus_fabric.sv
// Data-side interconnect between the CPU load/store port and NUM_SLAVES slaves.
// One registered transaction at a time, with per-slave ready, unmapped/timeout errors and an error counter.
module data_bus_fabric #(
   parameter int                               NUM_SLAVES = 4,
   parameter int                               ADDR_WIDTH = 32,
   parameter int                               DATA_WIDTH = 32,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE   = {32'h20000000, 32'h02000000, 32'h10000000, 32'h00000000},
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK   = {32'hFFFF0000, 32'hFFFF0000, 32'hFFF00000, 32'hFFF80000},
   parameter int                               TIMEOUT    = 16,
   parameter logic [DATA_WIDTH-1:0]            ERR_DATA   = 32'hDEADBEEF
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             m_req,
   input  logic                             m_we,
   input  logic [ADDR_WIDTH-1:0]            m_addr,
   input  logic [DATA_WIDTH-1:0]            m_wdata,
   input  logic [DATA_WIDTH/8-1:0]          m_be,
   input  logic [2:0]                       m_size,
   output logic                             m_busy,
   output logic                             m_ready,
   output logic                             m_err,
   output logic [DATA_WIDTH-1:0]            m_rdata,
   output logic [NUM_SLAVES-1:0]            s_sel,
   output logic                             s_we,
   output logic [ADDR_WIDTH-1:0]            s_addr,
   output logic [DATA_WIDTH-1:0]            s_wdata,
   output logic [DATA_WIDTH/8-1:0]          s_be,
   output logic [2:0]                       s_size,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
   input  logic [NUM_SLAVES-1:0]            s_ready,
   output logic [7:0]                       err_count
);

   localparam int BW = DATA_WIDTH/8;
   localparam int CW = $clog2(TIMEOUT+2);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ERROR = 2'd2} state_e;
   state_e state_q, state_d;

   logic [NUM_SLAVES-1:0] s_sel_q, s_sel_d, hit_oh;
   logic [ADDR_WIDTH-1:0] hit_mask;
   logic                  s_we_q, s_we_d;
   logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
   logic [DATA_WIDTH-1:0] s_wdata_q, s_wdata_d;
   logic [BW-1:0]         s_be_q, s_be_d;
   logic [2:0]            s_size_q, s_size_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  m_ready_q, m_ready_d, m_err_q, m_err_d;
   logic [DATA_WIDTH-1:0] m_rdata_q, m_rdata_d, sel_rdata;
   logic [7:0]            err_cnt_q, err_cnt_d;
   logic                  sel_ready, tmo;

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      hit_oh   = '0;
      hit_mask = '0;
      for (int i = NUM_SLAVES-1; i >= 0; i--) begin
         if ((m_addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
            hit_oh    = '0;
            hit_oh[i] = 1'b1;
            hit_mask  = SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++)
         if (s_sel_q[i]) sel_rdata = sel_rdata | s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
   end

   assign sel_ready = |(s_ready & s_sel_q);
   assign tmo       = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (m_req) state_d = (hit_oh != '0) ? ACCESS : ERROR;
         ACCESS:  if (sel_ready || tmo) state_d = IDLE;
         ERROR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_sel_d   = s_sel_q;
      s_we_d    = s_we_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      s_be_d    = s_be_q;
      s_size_d  = s_size_q;
      cnt_d     = cnt_q;
      m_ready_d = 1'b0;
      m_err_d   = 1'b0;
      m_rdata_d = m_rdata_q;
      case (state_q)
         IDLE: if (m_req) begin
            s_sel_d   = hit_oh;
            s_we_d    = m_we;
            s_addr_d  = m_addr & ~hit_mask;
            s_wdata_d = m_wdata;
            s_be_d    = m_be;
            s_size_d  = m_size;
            cnt_d     = '0;
         end
         ACCESS: begin
            // Ready is checked first so a response in the expiry cycle still completes cleanly.
            if (sel_ready) begin
               m_ready_d = 1'b1;
               s_sel_d   = '0;
               if (!s_we_q) m_rdata_d = sel_rdata;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (tmo) begin
                  m_ready_d = 1'b1;
                  m_err_d   = 1'b1;
                  s_sel_d   = '0;
                  if (!s_we_q) m_rdata_d = ERR_DATA;
               end
            end
         end
         ERROR: begin
            m_ready_d = 1'b1;
            m_err_d   = 1'b1;
            if (!s_we_q) m_rdata_d = ERR_DATA;
         end
         default: ;
      endcase
      err_cnt_d = (m_err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_sel_q   <= '0;
         s_we_q    <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         s_be_q    <= '0;
         s_size_q  <= '0;
         cnt_q     <= '0;
         m_ready_q <= 1'b0;
         m_err_q   <= 1'b0;
         m_rdata_q <= '0;
         err_cnt_q <= '0;
      end else begin
         s_sel_q   <= s_sel_d;
         s_we_q    <= s_we_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         s_be_q    <= s_be_d;
         s_size_q  <= s_size_d;
         cnt_q     <= cnt_d;
         m_ready_q <= m_ready_d;
         m_err_q   <= m_err_d;
         m_rdata_q <= m_rdata_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign m_busy    = (state_q != IDLE);
   assign m_ready   = m_ready_q;
   assign m_err     = m_err_q;
   assign m_rdata   = m_rdata_q;
   assign s_sel     = s_sel_q;
   assign s_we      = s_we_q;
   assign s_addr    = s_addr_q;
   assign s_wdata   = s_wdata_q;
   assign s_be      = s_be_q;
   assign s_size    = s_size_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_data_bus_fabric.sv
// Bench for data_bus_fabric: table of transactions plus hand sequences, completions checked from a scoreboard.
module tb_data_bus_fabric;

   localparam logic [31:0] ERR = 32'hDEADBEEF;

   logic        clk, rst_n;
   logic        m_req, m_we;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_be;
   logic [2:0]  m_size;
   logic        m_busy, m_ready, m_err;
   logic [31:0] m_rdata;
   logic [3:0]  s_sel;
   logic        s_we;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  s_be;
   logic [2:0]  s_size;
   logic [127:0] s_rdata;
   logic [3:0]  s_ready;
   logic [7:0]  err_count;

   data_bus_fabric dut (
      .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_be(m_be), .m_size(m_size), .m_busy(m_busy),
      .m_ready(m_ready), .m_err(m_err), .m_rdata(m_rdata), .s_sel(s_sel),
      .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
      .s_size(s_size), .s_rdata(s_rdata), .s_ready(s_ready), .err_count(err_count)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          slv;
      int          lat;     // wait cycles before s_ready, -1 = never
      logic        noise;   // unselected slaves assert s_ready
      logic [3:0]  sel;
      logic [31:0] saddr;
      logic        err;
      int          edges;   // edges from accept to m_ready
   } vec_t;

   typedef struct {
      logic        err;
      logic [31:0] rd;
      logic [7:0]  ec;
      int          at;
   } exp_t;

   exp_t        sb[$];
   vec_t        vecs[12];
   logic [31:0] slv_data[4];
   int          lat[4];
   logic        noise;
   logic [31:0] rd_model;
   logic [7:0]  ec_model;
   int          cyc;
   int          checks, errors;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Slave model: selected slave answers after lat[i] wait cycles.
   initial begin
      int selcnt;
      selcnt  = 0;
      s_ready = '0;
      forever begin
         @(negedge clk);
         s_ready = '0;
         if (s_sel != 4'd0) begin
            for (int i = 0; i < 4; i++) begin
               if (s_sel[i] && lat[i] == selcnt) s_ready[i] = 1'b1;
               if (!s_sel[i] && noise) s_ready[i] = 1'b1;
            end
            selcnt++;
         end else selcnt = 0;
      end
   end

   // Completion monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && m_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ready: got m_ready=1 at cycle %0d expected none", cyc);
            end else begin
               e = sb.pop_front();
               chk("m_err", m_err, e.err);
               chk("m_rdata", m_rdata, e.rd);
               chk("err_count", err_count, e.ec);
               chk("latency", cyc, e.at);
            end
         end
      end
   end

   task automatic push_exp(input logic we, input logic err, input logic [31:0] data, input int at);
      exp_t e;
      if (!we) rd_model = err ? ERR : data;
      if (err && ec_model != 8'hFF) ec_model++;
      e.err = err; e.rd = rd_model; e.ec = ec_model; e.at = at;
      sb.push_back(e);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (m_busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (m_busy) chk(name, 1, 0);
   endtask

   task automatic run(input vec_t v, input logic [2:0] sz);
      int acc, selc, n;
      for (int i = 0; i < 4; i++) lat[i] = v.lat;
      noise = v.noise;
      @(negedge clk);
      m_req = 1'b1; m_we = v.we; m_addr = v.addr; m_wdata = v.wdata; m_be = v.be; m_size = sz;
      @(posedge clk); #1;
      acc   = cyc;
      m_req = 1'b0;
      push_exp(v.we, v.err, (v.slv >= 0) ? slv_data[v.slv] : 32'h0, acc + v.edges);
      chk("accept_busy", m_busy, 1);
      chk("accept_sel", s_sel, v.sel);
      selc = 0;
      n    = 0;
      forever begin
         @(negedge clk);
         if (!m_busy) break;
         if (n >= 200) begin
            chk("txn_timeout", m_busy, 0);
            break;
         end
         n++;
         if (s_sel != 4'd0) begin
            selc++;
            chk("hold_ctl", {s_sel, s_addr, s_we, s_be, s_size}, {v.sel, v.saddr, v.we, v.be, sz});
            chk("hold_wdata", s_wdata, v.wdata);
         end
      end
      chk("sel_cycles", selc, (v.sel != 4'd0) ? v.edges : 0);
      noise = 1'b0;
   endtask

   initial begin
      int a0, a1;
      vec_t u;
      checks = 0; errors = 0;
      rd_model = '0; ec_model = '0; noise = 1'b0;
      for (int i = 0; i < 4; i++) lat[i] = 0;
      slv_data[0] = 32'hA0A00A0A; slv_data[1] = 32'h12345678;
      slv_data[2] = 32'hC2C22C2C; slv_data[3] = 32'hD3D33D3D;
      s_rdata = {slv_data[3], slv_data[2], slv_data[1], slv_data[0]};
      m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0; m_size = '0;

      //           we    addr          wdata         be     slv lat noise sel     saddr         err edges
      vecs[0]  = '{1'b0, 32'h10000004, 32'h00000000, 4'hF,  1,  0, 1'b0, 4'b0010, 32'h00000004, 1'b0, 1};
      vecs[1]  = '{1'b1, 32'h20000008, 32'hA5A5A5A5, 4'h3,  3,  3, 1'b0, 4'b1000, 32'h00000008, 1'b0, 4};
      vecs[2]  = '{1'b0, 32'h40000000, 32'h00000000, 4'hF, -1,  0, 1'b0, 4'b0000, 32'h00000000, 1'b1, 1};
      vecs[3]  = '{1'b0, 32'h02000010, 32'h00000000, 4'hF,  2,  0, 1'b0, 4'b0100, 32'h00000010, 1'b0, 1};
      vecs[4]  = '{1'b0, 32'h00000020, 32'h11111111, 4'h1,  0,  2, 1'b0, 4'b0001, 32'h00000020, 1'b0, 3};
      vecs[5]  = '{1'b1, 32'h00070000, 32'h0F0F0F0F, 4'hF,  0,  0, 1'b0, 4'b0001, 32'h00070000, 1'b0, 1};
      vecs[6]  = '{1'b1, 32'h30000000, 32'h55555555, 4'hC, -1,  0, 1'b0, 4'b0000, 32'h00000000, 1'b1, 1};
      vecs[7]  = '{1'b0, 32'h1000FFFC, 32'h00000000, 4'hF,  1,  5, 1'b1, 4'b0010, 32'h0000FFFC, 1'b0, 6};
      vecs[8]  = '{1'b0, 32'h0200FFF0, 32'h00000000, 4'hF,  2, -1, 1'b0, 4'b0100, 32'h0000FFF0, 1'b1, 16};
      vecs[9]  = '{1'b0, 32'h02000000, 32'h00000000, 4'hF,  2, 15, 1'b0, 4'b0100, 32'h00000000, 1'b0, 16};
      vecs[10] = '{1'b1, 32'h2000FFFC, 32'hCAFEF00D, 4'h8,  3, -1, 1'b0, 4'b1000, 32'h0000FFFC, 1'b1, 16};
      vecs[11] = '{1'b0, 32'h0007FFFC, 32'h00000000, 4'hF,  0, 14, 1'b0, 4'b0001, 32'h0007FFFC, 1'b0, 15};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_status", {m_busy, m_ready, m_err, s_sel, s_we, s_be, s_size}, 0);
      chk("rst_data", {s_addr, s_wdata}, 0);
      chk("rst_rdata_cnt", {m_rdata, err_count}, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) run(vecs[i], 3'(i));

      u = '{1'b0, 32'h40000000, 32'h0, 4'hF, -1, 0, 1'b0, 4'b0000, 32'h0, 1'b1, 1};
      for (int i = 0; i < 300; i++) begin
         u.addr = 32'h40000000 + 32'(i * 4);
         run(u, 3'd2);
      end
      chk("err_count_sat", err_count, 8'hFF);

      // Reset while a never-ready access is in flight.
      lat[2] = -1;
      @(negedge clk);
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h02000004;
      @(posedge clk); #1;
      m_req = 1'b0;
      chk("mid_sel", s_sel, 4'b0100);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_drop", {s_sel, m_busy, m_ready}, 0);
      chk("rst_cnt", err_count, 0);
      chk("rst_rdata", m_rdata, 0);
      rd_model = '0; ec_model = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_busy", m_busy, 0);

      // Back-to-back reads with m_req held high.
      lat[0] = 0; lat[1] = 0;
      @(negedge clk);
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h00000040; m_size = 3'd2;
      @(posedge clk); #1;
      a0 = cyc;
      push_exp(1'b0, 1'b0, slv_data[0], a0 + 1);
      chk("b2b_sel0", s_sel, 4'b0001);
      @(negedge clk);
      m_addr = 32'h10000080;
      @(posedge clk); #1;
      chk("b2b_gap", {s_sel, m_ready, m_busy}, {4'b0000, 1'b1, 1'b0});
      @(posedge clk); #1;
      a1 = cyc;
      push_exp(1'b0, 1'b0, slv_data[1], a1 + 1);
      chk("b2b_sel1", {s_sel, s_addr}, {4'b0010, 32'h00000080});
      m_req = 1'b0;
      wait_idle("b2b_idle");

      // m_req pulse while busy must be dropped.
      lat[2] = 3;
      @(negedge clk);
      m_req = 1'b1; m_addr = 32'h02000004;
      @(posedge clk); #1;
      a0 = cyc;
      push_exp(1'b0, 1'b0, slv_data[2], a0 + 4);
      m_req = 1'b0;
      @(negedge clk);
      m_req = 1'b1; m_addr = 32'h40000000;
      @(negedge clk);
      m_req = 1'b0;
      wait_idle("pulse_idle");
      repeat (3) begin
         @(negedge clk);
         chk("pulse_ignored", {m_busy, err_count}, 0);
      end

      repeat (5) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
